// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) driving
// DIGITS active-low 7-segment displays with optional leading-zero blanking.
module bcd_display_driver #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    function automatic longint f_pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("bcd_display_driver: WIDTH must be in 1..16");
    end
    if (f_pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
        $error("bcd_display_driver: DIGITS too small to hold 2^WIDTH-1");
    end

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_sr;
    logic [BW-1:0]      r_scratch;
    logic               r_busy;
    logic               r_done;
    logic [BW-1:0]      r_bcd;
    logic [SW-1:0]      r_seg;

    logic [BW-1:0]      w_adj;
    logic [BW-1:0]      w_scratch_nxt;
    logic [SW-1:0]      w_seg_nxt;

    // Add-3 correction followed by the one-bit shift of {scratch, shift register}.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
        w_scratch_nxt = (w_adj << 1) | BW'(r_sr[WIDTH-1]);
    end

    // Walk from the most significant digit; units digit is never blanked.
    always_comb begin
        logic v_lead;
        v_lead    = 1'b1;
        w_seg_nxt = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (w_scratch_nxt[4*k +: 4] != 4'd0) v_lead = 1'b0;
            if (BLANK_LZ != 0 && v_lead && k != 0) begin
                w_seg_nxt[7*k +: 7] = 7'b1111111;
            end else begin
                w_seg_nxt[7*k +: 7] = f_glyph(w_scratch_nxt[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_scratch <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_seg     <= '1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr      <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    r_scratch <= w_scratch_nxt;
                    r_sr      <= r_sr << 1;
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_bcd   <= w_scratch_nxt;
                        r_seg   <= w_seg_nxt;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign seg  = r_seg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: table vectors, timing/abort sequences and
// exhaustive sweeps, with a queue scoreboard checked on every done pulse.
module tb_bcd_display_driver;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0011000, GB = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_w;
    logic [7:0]  bin_a;
    logic [9:0]  bin_w;
    logic        busy_a, done_a, busy_nb, done_nb, busy_w, done_w;
    logic [11:0] bcd_a, bcd_nb;
    logic [20:0] seg_a, seg_nb;
    logic [15:0] bcd_w;
    logic [27:0] seg_w;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [11:0] bcd; logic [20:0] seg; logic [20:0] seg_nb; } exp8_t;
    typedef struct { logic [15:0] bcd; logic [27:0] seg; } exp10_t;
    typedef struct { logic [7:0] bin; logic [11:0] bcd; logic [20:0] seg; logic [20:0] seg_nb; } vec_t;

    exp8_t  q_a[$];
    exp10_t q_w[$];

    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .seg(seg_a)
    );
    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .seg(seg_nb)
    );
    bcd_display_driver #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .bin(bin_w),
        .busy(busy_w), .done(done_w), .bcd(bcd_w), .seg(seg_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] m_glyph(input int d);
        case (d)
            0: return G0; 1: return G1; 2: return G2; 3: return G3; 4: return G4;
            5: return G5; 6: return G6; 7: return G7; 8: return G8; 9: return G9;
            default: return GB;
        endcase
    endfunction

    function automatic logic [15:0] m_bcd(input int v, input int nd);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] m_seg(input int v, input int nd, input bit blz);
        logic [27:0] r;
        int dig[4];
        int x;
        bit lead;
        r = '1;
        x = v;
        for (int k = 0; k < 4; k++) begin
            dig[k] = x % 10;
            x = x / 10;
        end
        lead = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            if (dig[k] != 0) lead = 1'b0;
            r[7*k +: 7] = (blz && lead && k > 0) ? GB : m_glyph(dig[k]);
        end
        return r;
    endfunction

    function automatic exp8_t m_exp8(input int v);
        exp8_t e;
        e.bcd    = 12'(m_bcd(v, 3));
        e.seg    = 21'(m_seg(v, 3, 1'b1));
        e.seg_nb = 21'(m_seg(v, 3, 1'b0));
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done_a) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_a_unexpected: got done=1 required done=0 (bcd %0h)", bcd_a);
            end else begin
                exp8_t e;
                e = q_a.pop_front();
                check("bcd_a", bcd_a, e.bcd);
                check("seg_a", seg_a, e.seg);
                check("bcd_nb", bcd_nb, e.bcd);
                check("seg_nb", seg_nb, e.seg_nb);
                check("done_nb", done_nb, 1);
            end
        end
        if (!rst && done_w) begin
            if (q_w.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_w_unexpected: got done=1 required done=0 (bcd %0h)", bcd_w);
            end else begin
                exp10_t e;
                e = q_w.pop_front();
                check("bcd_w", bcd_w, e.bcd);
                check("seg_w", seg_w, e.seg);
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge following done.
    task automatic run_conv(input bit wide, input int v);
        int  lat;
        bit  busy_ok;
        if (wide) begin start_w = 1'b1; bin_w = 10'(v); end
        else begin start_a = 1'b1; bin_a = 8'(v); end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_w = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!(wide ? busy_w : busy_a)) busy_ok = 1'b0;
            if (wide ? done_w : done_a) begin
                lat = c;
                break;
            end
        end
        check($sformatf("latency_%0d", v), lat, wide ? 11 : 9);
        check($sformatf("busy_during_%0d", v), busy_ok, 1);
        @(posedge clk); #1;
        check($sformatf("busy_after_%0d", v), wide ? busy_w : busy_a, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[10];
        int   ndone;
        int   first;
        int   lat;

        tab[0] = '{8'd0,   12'h000, {GB, GB, G0}, {G0, G0, G0}};
        tab[1] = '{8'd255, 12'h255, {G2, G5, G5}, {G2, G5, G5}};
        tab[2] = '{8'd100, 12'h100, {G1, G0, G0}, {G1, G0, G0}};
        tab[3] = '{8'd7,   12'h007, {GB, GB, G7}, {G0, G0, G7}};
        tab[4] = '{8'd42,  12'h042, {GB, G4, G2}, {G0, G4, G2}};
        tab[5] = '{8'd58,  12'h058, {GB, G5, G8}, {G0, G5, G8}};
        tab[6] = '{8'd163, 12'h163, {G1, G6, G3}, {G1, G6, G3}};
        tab[7] = '{8'd209, 12'h209, {G2, G0, G9}, {G2, G0, G9}};
        tab[8] = '{8'd9,   12'h009, {GB, GB, G9}, {G0, G0, G9}};
        tab[9] = '{8'd10,  12'h010, {GB, G1, G0}, {G0, G1, G0}};

        rst = 1'b1; start_a = 1'b0; start_w = 1'b0; bin_a = '0; bin_w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_bcd_a", bcd_a, 0);
        check("rst_seg_a", seg_a, 21'h1FFFFF);
        check("rst_seg_nb", seg_nb, 21'h1FFFFF);
        check("rst_bcd_w", bcd_w, 0);
        check("rst_seg_w", seg_w, 28'hFFFFFFF);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            q_a.push_back('{tab[i].bcd, tab[i].seg, tab[i].seg_nb});
            run_conv(1'b0, int'(tab[i].bin));
        end

        // Outputs hold while idle even as bin wanders.
        for (int c = 0; c < 5; c++) begin
            bin_a = 8'(37 * c + 200);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("hold_bcd", bcd_a, 12'h010);
        check("hold_seg", seg_a, {GB, G1, G0});
        check("hold_busy", busy_a, 0);
        @(posedge clk); #1;

        // Start re-asserted while busy is ignored; next start taken at cycle 10.
        start_a = 1'b1; bin_a = 8'd42;
        q_a.push_back(m_exp8(42));
        @(posedge clk); #1;
        start_a = 1'b0;
        ndone = 0; first = -1;
        for (int c = 1; c <= 9; c++) begin
            if (c >= 3) begin start_a = 1'b1; bin_a = 8'd99; end
            @(negedge clk);
            if (done_a) begin ndone++; if (first < 0) first = c; end
            @(posedge clk); #1;
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_cycle", first, 9);
        q_a.push_back(m_exp8(99));
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = -1;
        for (int c = 11; c <= 40; c++) begin
            @(negedge clk);
            if (done_a) begin lat = c; break; end
        end
        check("restart_done_cycle", lat, 19);
        @(posedge clk); #1;

        // Reset at cycle 4 aborts with no done pulse.
        start_a = 1'b1; bin_a = 8'd123;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_bcd", bcd_a, 0);
        check("abort_seg", seg_a, 21'h1FFFFF);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        q_a.push_back(m_exp8(123));
        run_conv(1'b0, 123);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start_a = 1'b1; bin_a = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0;
        check("rst_prio_busy", busy_a, 0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("rst_prio_no_done", ndone, 0);
        @(posedge clk); #1;

        for (int v = 0; v < 256; v++) begin
            q_a.push_back(m_exp8(v));
            run_conv(1'b0, v);
        end

        for (int v = 0; v < 1024; v++) begin
            q_w.push_back('{m_bcd(v, 4), m_seg(v, 4, 1'b1)});
            run_conv(1'b1, v);
        end

        check("queue_a_drained", q_a.size(), 0);
        check("queue_w_drained", q_w.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter WIDTH, 8, binary input width (1..16).
REQ-002 SHALL have parameter DIGITS, 3, number of decimal digits and 7-segment displays; 10^DIGITS > 2^WIDTH-1 required, violation is an elaboration error.
REQ-003 SHALL have parameter BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-007 SHALL have port bin  input  WIDTH  unsigned value, captured in the cycle start is accepted.
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port bcd  output  4*DIGITS  registered packed BCD result, digit 0 (units) in bits [3:0].
REQ-011 SHALL have port seg  output  7*DIGITS  registered active-low segments, digit k in bits [7k+6:7k], bit order g,f,e,d,c,b,a (MSB..LSB).

Function
REQ-012 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-013 IDLE: start=1 SHALL load bin into shift register, clear BCD scratch, load iteration counter with WIDTH, go to SHIFT; start=0 stays in IDLE.
REQ-014 SHALL use sequential double-dabble in SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit; counter decrements.
REQ-015 SHALL go SHIFT -> DONE after exactly WIDTH shift cycles.
REQ-016 DONE SHALL last one cycle: done=1, bcd and seg updated in that cycle, then go to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: done high WIDTH+1 cycles after the accepting edge (start cycle = 0); next start accepted at cycle WIDTH+2.
REQ-018 start while busy=1 SHALL be ignored (not queued); bin changes while busy SHALL not affect the result.
REQ-019 bcd and seg SHALL hold their last value between conversions and only change in DONE.
REQ-020 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000; blank=1111111.
REQ-021 BLANK_LZ=1: digit k>0 SHALL be blank if it and all higher digits are zero; digit 0 always displayed; bcd output SHALL never be blanked.
REQ-022 BLANK_LZ=0: all digits SHALL show their glyph.
REQ-023 No arithmetic overflow SHALL be possible given REQ-002; no overflow output exists.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, busy=0, done=0, bcd=0, seg all ones (all displays dark), counter and scratch cleared.
REQ-025 rst during SHIFT or DONE SHALL abort the conversion with no done pulse; rst SHALL take priority over start in the same cycle.

Verification (WIDTH=8, DIGITS=3 unless stated)
REQ-026 bin=0, start pulse -> done at cycle 9, bcd=12'h000, seg digit0=1000000, digits1,2=1111111.
REQ-027 bin=255 -> bcd=12'h255, seg digit2=0100100, digit1=0010010, digit0=0010010, busy high cycles 1..9.
REQ-028 bin=100 -> bcd=12'h100, digit1 shows 1000000 (interior zero not blanked); BLANK_LZ=0, bin=7 -> seg 1000000,1000000,1111000.
REQ-029 bin=42 started, start re-asserted with bin=99 at cycles 3..9 -> single done at cycle 9 with bcd=12'h042; start at cycle 10 with bin=99 accepted, done at cycle 19, bcd=12'h099.
REQ-030 rst at cycle 4 of a conversion -> no done, busy=0 next cycle, seg all ones, bcd=0; following start completes normally.
REQ-031 Exhaustive sweep bin=0..255 (and WIDTH=10, DIGITS=4, bin=0..1023) -> bcd equals decimal of bin, seg matches REQ-020/021 for every value.
